prco_mem_wb: RTL and testbench

- Memory-access and write-back stage of the prco core; consumes the ALU stage's outputs (result, RAM/register enables, branch flag).
- Performs LW/SW transactions on the data-RAM request/acknowledge bus and writes results into the register file.
- Issues PC updates for taken branches and signals completion so fetch can resume.

---
 rtl/prco_mem_wb_pkg.sv | 35 +++
 rtl/prco_mem_wb_if.sv | 21 ++
 rtl/prco_mem_wb_req_ctl.sv | 50 +++++
 rtl/prco_mem_wb.sv | 132 +++++++++++++
 tb/tb_prco_mem_wb.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/prco_mem_wb_pkg.sv
// Shared ISA opcodes, stage state encodings and status-bit positions for the
// prco memory/write-back stage.
package prco_mem_wb_pkg;

    typedef logic [4:0] op_t;

    localparam op_t PRCO_OP_NOP  = 5'h00;
    localparam op_t PRCO_OP_MOV  = 5'h01;
    localparam op_t PRCO_OP_MOVI = 5'h02;
    localparam op_t PRCO_OP_ADD  = 5'h03;
    localparam op_t PRCO_OP_ADDI = 5'h04;
    localparam op_t PRCO_OP_SUBI = 5'h05;
    localparam op_t PRCO_OP_AND  = 5'h06;
    localparam op_t PRCO_OP_OR   = 5'h07;
    localparam op_t PRCO_OP_XOR  = 5'h08;
    localparam op_t PRCO_OP_NOT  = 5'h09;
    localparam op_t PRCO_OP_CMP  = 5'h0A;
    localparam op_t PRCO_OP_JMP  = 5'h0B;
    localparam op_t PRCO_OP_LW   = 5'h0C;
    localparam op_t PRCO_OP_SW   = 5'h0D;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_WB       = 2'd2;

    localparam int STAT_W           = 2;
    localparam int STAT_FAULT_BIT   = 0;
    localparam int STAT_OVERRUN_BIT = 1;

    // JMP goes to the PC and NOP retires silently; everything else lands in the register file.
    function automatic logic op_writes_reg(input op_t op);
        return (op != PRCO_OP_NOP) && (op != PRCO_OP_JMP);
    endfunction

endpackage

// File: rtl/prco_mem_wb_if.sv
// Data-RAM request/acknowledge bus between the memory stage (master) and the RAM (slave).
interface prco_mem_wb_if #(
    parameter int DATA_W = 16
);
    logic              q_mem_req;
    logic              q_mem_we;
    logic [DATA_W-1:0] q_mem_addr;
    logic [DATA_W-1:0] q_mem_wdata;
    logic              i_mem_ack;
    logic [DATA_W-1:0] i_mem_rdata;

    modport master (
        output q_mem_req, q_mem_we, q_mem_addr, q_mem_wdata,
        input  i_mem_ack, i_mem_rdata
    );

    modport slave (
        input  q_mem_req, q_mem_we, q_mem_addr, q_mem_wdata,
        output i_mem_ack, i_mem_rdata
    );
endinterface

// File: rtl/prco_mem_wb_req_ctl.sv
// RAM request holder: keeps req/we/addr/wdata stable until ack or until the
// ack timeout expires, and reports which of the two ended the transaction.
module prco_mem_req_ctl #(
    parameter int DATA_W      = 16,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              start_we,
    input  logic [DATA_W-1:0] start_addr,
    input  logic [DATA_W-1:0] start_wdata,
    prco_mem_wb_if.master     mem,
    output logic              ack_hit,
    output logic              timeout,
    output logic [DATA_W-1:0] rdata
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;

    // An ack on the final allowed cycle wins over the timeout.
    assign ack_hit = mem.q_mem_req & mem.i_mem_ack;
    assign timeout = mem.q_mem_req & ~mem.i_mem_ack & (wait_cnt == CNT_LAST);
    assign rdata   = mem.i_mem_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem.q_mem_req   <= 1'b0;
            mem.q_mem_we    <= 1'b0;
            mem.q_mem_addr  <= '0;
            mem.q_mem_wdata <= '0;
            wait_cnt        <= '0;
        end else if (start) begin
            mem.q_mem_req   <= 1'b1;
            mem.q_mem_we    <= start_we;
            mem.q_mem_addr  <= start_addr;
            mem.q_mem_wdata <= start_wdata;
            wait_cnt        <= '0;
        end else if (ack_hit || timeout) begin
            mem.q_mem_req   <= 1'b0;
            wait_cnt        <= '0;
        end else if (mem.q_mem_req) begin
            wait_cnt        <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/prco_mem_wb.sv
// Memory-access / write-back stage of the prco core: runs LW/SW on the RAM
// bus, writes the register file, loads the PC on taken jumps, and retires.
module prco_mem_wb
    import prco_mem_wb_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int REG_AW      = 3,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ce_ram,
    input  logic              i_ce_reg,
    input  logic              i_should_branch,
    input  op_t               i_op,
    input  logic [DATA_W-1:0] i_result,
    input  logic [DATA_W-1:0] i_store_data,
    input  logic [REG_AW-1:0] i_rd,
    prco_mem_wb_if.master     mem,
    output logic              q_reg_we,
    output logic [REG_AW-1:0] q_reg_waddr,
    output logic [DATA_W-1:0] q_reg_wdata,
    output logic              q_pc_we,
    output logic [DATA_W-1:0] q_pc_wdata,
    output logic              q_busy,
    output logic              q_done,
    output logic              q_overrun,
    output logic              q_fault
);

    logic [1:0]        state;
    op_t               op_q;
    logic [REG_AW-1:0] rd_q;
    logic [STAT_W-1:0] status;
    logic              start_mem;
    logic              ack_hit;
    logic              timeout;
    logic [DATA_W-1:0] mem_rdata;
    logic              overrun_evt;

    assign start_mem   = (state == ST_IDLE) && i_ce_ram;
    assign overrun_evt = ((state != ST_IDLE) && (i_ce_ram || i_ce_reg)) ||
                         ((state == ST_IDLE) && i_ce_ram && i_ce_reg);

    assign q_busy    = (state != ST_IDLE);
    assign q_fault   = status[STAT_FAULT_BIT];
    assign q_overrun = status[STAT_OVERRUN_BIT];

    prco_mem_req_ctl #(
        .DATA_W      (DATA_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_req_ctl (
        .clk         (i_clk),
        .rst_n       (i_rst_n),
        .start       (start_mem),
        .start_we    (i_op == PRCO_OP_SW),
        .start_addr  (i_result),
        .start_wdata (i_store_data),
        .mem         (mem),
        .ack_hit     (ack_hit),
        .timeout     (timeout),
        .rdata       (mem_rdata)
    );

    // Register ops retire straight from IDLE; RAM ops retire from MEM_WAIT.
    // WB is the one-cycle retire slot in which the done/write pulses are visible.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            op_q        <= PRCO_OP_NOP;
            rd_q        <= '0;
            status      <= '0;
            q_reg_we    <= 1'b0;
            q_reg_waddr <= '0;
            q_reg_wdata <= '0;
            q_pc_we     <= 1'b0;
            q_pc_wdata  <= '0;
            q_done      <= 1'b0;
        end else begin
            q_reg_we <= 1'b0;
            q_pc_we  <= 1'b0;
            q_done   <= 1'b0;
            if (overrun_evt) begin
                status[STAT_OVERRUN_BIT] <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (i_ce_ram) begin
                        op_q  <= i_op;
                        rd_q  <= i_rd;
                        state <= ST_MEM_WAIT;
                    end else if (i_ce_reg) begin
                        op_q   <= i_op;
                        rd_q   <= i_rd;
                        state  <= ST_WB;
                        q_done <= 1'b1;
                        if (i_op == PRCO_OP_JMP) begin
                            q_pc_we    <= i_should_branch;
                            q_pc_wdata <= i_result;
                        end else if (op_writes_reg(i_op)) begin
                            q_reg_we    <= 1'b1;
                            q_reg_waddr <= i_rd;
                            q_reg_wdata <= i_result;
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    if (ack_hit) begin
                        state  <= ST_WB;
                        q_done <= 1'b1;
                        if (op_q == PRCO_OP_LW) begin
                            q_reg_we    <= 1'b1;
                            q_reg_waddr <= rd_q;
                            q_reg_wdata <= mem_rdata;
                        end
                    end else if (timeout) begin
                        state                  <= ST_WB;
                        q_done                 <= 1'b1;
                        status[STAT_FAULT_BIT] <= 1'b1;
                    end
                end
                ST_WB: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prco_mem_wb.sv
// Directed bench for prco_mem_wb with a hand-driven RAM acknowledge and a short ack timeout.
module tb_prco_mem_wb;
    import prco_mem_wb_pkg::*;

    localparam int DATA_W      = 16;
    localparam int REG_AW      = 3;
    localparam int ACK_TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ce_ram;
    logic              ce_reg;
    logic              should_branch;
    op_t               op;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [REG_AW-1:0] rd;
    logic              reg_we;
    logic [REG_AW-1:0] reg_waddr;
    logic [DATA_W-1:0] reg_wdata;
    logic              pc_we;
    logic [DATA_W-1:0] pc_wdata;
    logic              busy;
    logic              done;
    logic              overrun;
    logic              fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prco_mem_wb_if #(.DATA_W(DATA_W)) mem_bus ();

    prco_mem_wb #(
        .DATA_W      (DATA_W),
        .REG_AW      (REG_AW),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_ce_ram        (ce_ram),
        .i_ce_reg        (ce_reg),
        .i_should_branch (should_branch),
        .i_op            (op),
        .i_result        (result),
        .i_store_data    (store_data),
        .i_rd            (rd),
        .mem             (mem_bus),
        .q_reg_we        (reg_we),
        .q_reg_waddr     (reg_waddr),
        .q_reg_wdata     (reg_wdata),
        .q_pc_we         (pc_we),
        .q_pc_wdata      (pc_wdata),
        .q_busy          (busy),
        .q_done          (done),
        .q_overrun       (overrun),
        .q_fault         (fault)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Holds one enable pulse across a single rising edge, then returns at the next falling edge.
    task automatic applyStimulus(input logic ram_en, input logic reg_en, input logic br,
                                 input op_t o, input logic [DATA_W-1:0] res,
                                 input logic [DATA_W-1:0] st, input logic [REG_AW-1:0] r);
        ce_ram        = ram_en;
        ce_reg        = reg_en;
        should_branch = br;
        op            = o;
        result        = res;
        store_data    = st;
        rd            = r;
        @(negedge clk);
        ce_ram = 1'b0;
        ce_reg = 1'b0;
    endtask

    initial begin
        rst_n                = 1'b0;
        ce_ram               = 1'b0;
        ce_reg               = 1'b0;
        should_branch        = 1'b0;
        op                   = PRCO_OP_NOP;
        result               = '0;
        store_data           = '0;
        rd                   = '0;
        mem_bus.i_mem_ack    = 1'b0;
        mem_bus.i_mem_rdata  = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_req",     32'(mem_bus.q_mem_req), 32'd0);
        checkOutput("rst_reg_we",  32'(reg_we),  32'd0);
        checkOutput("rst_done",    32'(done),    32'd0);
        checkOutput("rst_busy",    32'(busy),    32'd0);
        checkOutput("rst_fault",   32'(fault),   32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] ADD retirement");
        applyStimulus(1'b0, 1'b1, 1'b0, PRCO_OP_ADD, 16'h1234, 16'h0000, 3'd3);
        checkOutput("add_reg_we", 32'(reg_we),    32'd1);
        checkOutput("add_waddr",  32'(reg_waddr), 32'd3);
        checkOutput("add_wdata",  32'(reg_wdata), 32'h1234);
        checkOutput("add_done",   32'(done),      32'd1);
        checkOutput("add_pc_we",  32'(pc_we),     32'd0);
        checkOutput("add_busy",   32'(busy),      32'd1);
        @(negedge clk);
        checkOutput("add_reg_we_off", 32'(reg_we), 32'd0);
        checkOutput("add_done_off",   32'(done),   32'd0);
        checkOutput("add_busy_off",   32'(busy),   32'd0);

        $display("[TB] LW with three wait states, ack on the final allowed cycle");
        applyStimulus(1'b1, 1'b0, 1'b0, PRCO_OP_LW, 16'h0040, 16'h0000, 3'd2);
        for (int i = 0; i < 4; i++) begin
            checkOutput("lw_req",  32'(mem_bus.q_mem_req),  32'd1);
            checkOutput("lw_addr", 32'(mem_bus.q_mem_addr), 32'h0040);
            checkOutput("lw_we",   32'(mem_bus.q_mem_we),   32'd0);
            checkOutput("lw_done_early", 32'(done), 32'd0);
            mem_bus.i_mem_ack   = (i == 3);
            mem_bus.i_mem_rdata = (i == 3) ? 16'hBEEF : 16'h0000;
            @(negedge clk);
        end
        mem_bus.i_mem_ack   = 1'b0;
        mem_bus.i_mem_rdata = '0;
        checkOutput("lw_req_off", 32'(mem_bus.q_mem_req), 32'd0);
        checkOutput("lw_reg_we",  32'(reg_we),    32'd1);
        checkOutput("lw_waddr",   32'(reg_waddr), 32'd2);
        checkOutput("lw_wdata",   32'(reg_wdata), 32'hBEEF);
        checkOutput("lw_done",    32'(done),      32'd1);
        checkOutput("lw_fault",   32'(fault),     32'd0);
        @(negedge clk);
        checkOutput("lw_busy_off", 32'(busy), 32'd0);

        $display("[TB] SW with immediate ack");
        applyStimulus(1'b1, 1'b0, 1'b0, PRCO_OP_SW, 16'h0010, 16'h00AA, 3'd1);
        checkOutput("sw_req",   32'(mem_bus.q_mem_req),   32'd1);
        checkOutput("sw_we",    32'(mem_bus.q_mem_we),    32'd1);
        checkOutput("sw_addr",  32'(mem_bus.q_mem_addr),  32'h0010);
        checkOutput("sw_wdata", 32'(mem_bus.q_mem_wdata), 32'h00AA);
        mem_bus.i_mem_ack = 1'b1;
        @(negedge clk);
        mem_bus.i_mem_ack = 1'b0;
        checkOutput("sw_req_off", 32'(mem_bus.q_mem_req), 32'd0);
        checkOutput("sw_done",    32'(done),   32'd1);
        checkOutput("sw_reg_we",  32'(reg_we), 32'd0);
        @(negedge clk);
        checkOutput("sw_busy_off", 32'(busy), 32'd0);

        $display("[TB] JMP taken and not taken");
        applyStimulus(1'b0, 1'b1, 1'b1, PRCO_OP_JMP, 16'h0100, 16'h0000, 3'd4);
        checkOutput("jmp_pc_we",    32'(pc_we),    32'd1);
        checkOutput("jmp_pc_wdata", 32'(pc_wdata), 32'h0100);
        checkOutput("jmp_reg_we",   32'(reg_we),   32'd0);
        checkOutput("jmp_done",     32'(done),     32'd1);
        @(negedge clk);
        checkOutput("jmp_pc_we_off", 32'(pc_we), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, PRCO_OP_JMP, 16'h0200, 16'h0000, 3'd4);
        checkOutput("jmpn_pc_we",  32'(pc_we),  32'd0);
        checkOutput("jmpn_reg_we", 32'(reg_we), 32'd0);
        checkOutput("jmpn_done",   32'(done),   32'd1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0, PRCO_OP_NOP, 16'h7777, 16'h0000, 3'd6);
        checkOutput("nop_reg_we", 32'(reg_we), 32'd0);
        checkOutput("nop_done",   32'(done),   32'd1);
        @(negedge clk);

        $display("[TB] Enable pulse during MEM_WAIT");
        applyStimulus(1'b1, 1'b0, 1'b0, PRCO_OP_LW, 16'h0020, 16'h0000, 3'd5);
        checkOutput("ovr_overrun_pre", 32'(overrun), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, PRCO_OP_ADD, 16'hFFFF, 16'h0000, 3'd1);
        checkOutput("ovr_overrun", 32'(overrun), 32'd1);
        checkOutput("ovr_req",     32'(mem_bus.q_mem_req),  32'd1);
        checkOutput("ovr_addr",    32'(mem_bus.q_mem_addr), 32'h0020);
        checkOutput("ovr_reg_we_none", 32'(reg_we), 32'd0);
        mem_bus.i_mem_ack   = 1'b1;
        mem_bus.i_mem_rdata = 16'h5555;
        @(negedge clk);
        mem_bus.i_mem_ack = 1'b0;
        checkOutput("ovr_reg_we", 32'(reg_we),    32'd1);
        checkOutput("ovr_waddr",  32'(reg_waddr), 32'd5);
        checkOutput("ovr_wdata",  32'(reg_wdata), 32'h5555);
        @(negedge clk);

        $display("[TB] Ack timeout");
        applyStimulus(1'b1, 1'b0, 1'b0, PRCO_OP_LW, 16'h0030, 16'h0000, 3'd7);
        for (int i = 0; i < ACK_TIMEOUT; i++) begin
            checkOutput("to_req", 32'(mem_bus.q_mem_req), 32'd1);
            @(negedge clk);
        end
        checkOutput("to_req_off", 32'(mem_bus.q_mem_req), 32'd0);
        checkOutput("to_fault",   32'(fault),  32'd1);
        checkOutput("to_done",    32'(done),   32'd1);
        checkOutput("to_reg_we",  32'(reg_we), 32'd0);
        @(negedge clk);
        checkOutput("to_busy_off", 32'(busy),  32'd0);
        checkOutput("to_fault_sticky", 32'(fault), 32'd1);

        $display("[TB] Reset mid-wait");
        applyStimulus(1'b1, 1'b0, 1'b0, PRCO_OP_SW, 16'h0050, 16'h1111, 3'd0);
        checkOutput("mr_req", 32'(mem_bus.q_mem_req), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("mr_req_off", 32'(mem_bus.q_mem_req),  32'd0);
        checkOutput("mr_addr",    32'(mem_bus.q_mem_addr), 32'd0);
        checkOutput("mr_done",    32'(done),    32'd0);
        checkOutput("mr_busy",    32'(busy),    32'd0);
        checkOutput("mr_fault",   32'(fault),   32'd0);
        checkOutput("mr_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] Simultaneous enables, RAM op wins");
        applyStimulus(1'b1, 1'b1, 1'b0, PRCO_OP_SW, 16'h0044, 16'h0011, 3'd2);
        checkOutput("sim_overrun", 32'(overrun), 32'd1);
        checkOutput("sim_req",     32'(mem_bus.q_mem_req), 32'd1);
        checkOutput("sim_we",      32'(mem_bus.q_mem_we),  32'd1);
        checkOutput("sim_done",    32'(done), 32'd0);
        mem_bus.i_mem_ack = 1'b1;
        @(negedge clk);
        mem_bus.i_mem_ack = 1'b0;
        checkOutput("sim_done_ack", 32'(done),   32'd1);
        checkOutput("sim_reg_we",   32'(reg_we), 32'd0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
